ysyx_22050854_pc_gen: RTL and testbench

Parametrised PC-generation unit for the NPC pipeline front end. It holds the fetch PC, drives IF through a valid/ready handshake, and predicts next PC with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It applies redirects from ID/EX branch resolution and from CSR traps/mret. It replaces the non-predicting PC register and its pc+4/pc+imm/src1+imm next-PC mux.

---
 rtl/ysyx_22050854_pc_gen.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_22050854_pc_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050854_pc_gen
// Purpose  : Fetch-PC generator for the NPC front end. It holds the fetch PC,
//            offers it to IF over a valid/ready handshake, and predicts the
//            next PC from a direct-mapped BTB of 2-bit saturating counters.
//            Redirects arrive from branch resolution (ID/EX) and from the
//            CSR file (trap/ecall/mret).
// Ports    : clock, reset_n        - clock, async active-low reset
//            fetch_valid/ready     - IF handshake
//            fetch_pc, pred_*      - current PC and its prediction
//            stall                 - freeze the PC (no handshake advance)
//            res_*                 - resolution of one branch/jump
//            csr_redirect, csr_pc  - CSR redirect
//            flush                 - kill younger instructions (combinational)
//            perf_pred/mispred     - resolved / mispredicted counters
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050854_pc_gen #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          BTB_ENTRIES = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            stall,
  output logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_is_branch,
  input  logic            res_is_jump,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_mispredict,
  input  logic            csr_redirect,
  input  logic [XLEN-1:0] csr_pc,
  output logic            flush,
  output logic [31:0]     perf_pred,
  output logic [31:0]     perf_mispred
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  // PC / handshake state
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            fetch_valid_q;
  logic [31:0]     perf_pred_q, perf_pred_d;
  logic [31:0]     perf_mispred_q, perf_mispred_d;

  // BTB state
  logic             btb_valid_q  [BTB_ENTRIES];
  logic             btb_valid_d  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_d    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target_q [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target_d [BTB_ENTRIES];
  logic [1:0]       btb_ctr_q    [BTB_ENTRIES];
  logic [1:0]       btb_ctr_d    [BTB_ENTRIES];
  logic             btb_jmp_q    [BTB_ENTRIES];
  logic             btb_jmp_d    [BTB_ENTRIES];

  logic [IDX-1:0]  w_lkp_idx;
  logic            w_lkp_hit;
  logic [IDX-1:0]  w_upd_idx;
  logic            w_upd_hit;
  logic            w_upd_en;
  logic            w_mispred;
  logic            w_unused;

  // Instruction alignment bits of res_pc carry no information here.
  assign w_unused = ^res_pc[1:0];

  // --------------------------------------------------------------------------
  // Lookup: reads only registered BTB state, so an update this cycle is not
  // visible until the next one.
  // --------------------------------------------------------------------------
  assign w_lkp_idx = fetch_pc_q[IDX+1:2];
  assign w_lkp_hit = btb_valid_q[w_lkp_idx] &&
                     (btb_tag_q[w_lkp_idx] == fetch_pc_q[XLEN-1:IDX+2]);

  assign pred_taken  = w_lkp_hit && (btb_jmp_q[w_lkp_idx] || btb_ctr_q[w_lkp_idx][1]);
  assign pred_target = pred_taken ? btb_target_q[w_lkp_idx]
                                  : fetch_pc_q + XLEN'(4);

  assign fetch_pc    = fetch_pc_q;
  assign fetch_valid = fetch_valid_q;

  assign w_mispred = res_valid && res_mispredict;
  assign flush     = csr_redirect || w_mispred;

  // --------------------------------------------------------------------------
  // Next PC, highest priority first. Redirects ignore stall/fetch_ready.
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (csr_redirect) begin
      fetch_pc_d = csr_pc;
    end else if (w_mispred) begin
      fetch_pc_d = res_target;
    end else if (fetch_valid_q && fetch_ready && !stall) begin
      fetch_pc_d = pred_target;
    end
  end

  // --------------------------------------------------------------------------
  // BTB update and performance counters. CSR redirects never touch these;
  // resolution still updates even when a CSR redirect wins the PC.
  // --------------------------------------------------------------------------
  assign w_upd_en  = res_valid && (res_is_branch || res_is_jump);
  assign w_upd_idx = res_pc[IDX+1:2];
  assign w_upd_hit = btb_valid_q[w_upd_idx] &&
                     (btb_tag_q[w_upd_idx] == res_pc[XLEN-1:IDX+2]);

  always_comb begin
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      btb_valid_d[i]  = btb_valid_q[i];
      btb_tag_d[i]    = btb_tag_q[i];
      btb_target_d[i] = btb_target_q[i];
      btb_ctr_d[i]    = btb_ctr_q[i];
      btb_jmp_d[i]    = btb_jmp_q[i];
    end
    perf_pred_d    = perf_pred_q;
    perf_mispred_d = perf_mispred_q;

    if (w_upd_en) begin
      perf_pred_d = perf_pred_q + 32'd1;
      if (res_mispredict) begin
        perf_mispred_d = perf_mispred_q + 32'd1;
      end

      if (w_upd_hit) begin
        // Saturating counter: clamp at 2'b11 and 2'b00.
        if (res_taken) begin
          if (btb_ctr_q[w_upd_idx] != 2'b11) begin
            btb_ctr_d[w_upd_idx] = btb_ctr_q[w_upd_idx] + 2'b01;
          end
        end else begin
          if (btb_ctr_q[w_upd_idx] != 2'b00) begin
            btb_ctr_d[w_upd_idx] = btb_ctr_q[w_upd_idx] - 2'b01;
          end
        end
        btb_target_d[w_upd_idx] = res_target;
        btb_jmp_d[w_upd_idx]    = res_is_jump;
      end else if (res_taken) begin
        // Allocate only on taken; new entries start weakly taken.
        btb_valid_d[w_upd_idx]  = 1'b1;
        btb_tag_d[w_upd_idx]    = res_pc[XLEN-1:IDX+2];
        btb_target_d[w_upd_idx] = res_target;
        btb_ctr_d[w_upd_idx]    = 2'b10;
        btb_jmp_d[w_upd_idx]    = res_is_jump;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q     <= XLEN'(RESET_PC);
      fetch_valid_q  <= 1'b0;
      perf_pred_q    <= 32'd0;
      perf_mispred_q <= 32'd0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      // Valid rises on the first edge out of reset and then stays high.
      fetch_valid_q  <= 1'b1;
      perf_pred_q    <= perf_pred_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  generate
    for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_btb
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          btb_valid_q[g]  <= 1'b0;
          btb_tag_q[g]    <= '0;
          btb_target_q[g] <= '0;
          btb_ctr_q[g]    <= 2'b01;
          btb_jmp_q[g]    <= 1'b0;
        end else begin
          btb_valid_q[g]  <= btb_valid_d[g];
          btb_tag_q[g]    <= btb_tag_d[g];
          btb_target_q[g] <= btb_target_d[g];
          btb_ctr_q[g]    <= btb_ctr_d[g];
          btb_jmp_q[g]    <= btb_jmp_d[g];
        end
      end
    end
  endgenerate

  assign perf_pred    = perf_pred_q;
  assign perf_mispred = perf_mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050854_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050854_pc_gen
// Purpose  : Directed self-checking bench for ysyx_22050854_pc_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050854_pc_gen;

  logic        clock;
  logic        reset_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        stall;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_is_branch;
  logic        res_is_jump;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_mispredict;
  logic        csr_redirect;
  logic [31:0] csr_pc;
  logic        flush;
  logic [31:0] perf_pred;
  logic [31:0] perf_mispred;

  int n_total = 0;
  int n_pass  = 0;

  ysyx_22050854_pc_gen dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .stall          (stall),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_is_branch  (res_is_branch),
    .res_is_jump    (res_is_jump),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .res_mispredict (res_mispredict),
    .csr_redirect   (csr_redirect),
    .csr_pc         (csr_pc),
    .flush          (flush),
    .perf_pred      (perf_pred),
    .perf_mispred   (perf_mispred)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one edge; sample 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_res();
    res_valid      = 1'b0;
    res_pc         = 32'h0;
    res_is_branch  = 1'b0;
    res_is_jump    = 1'b0;
    res_taken      = 1'b0;
    res_target     = 32'h0;
    res_mispredict = 1'b0;
  endtask

  // Resolve the branch at 0x80000010 without redirecting.
  task automatic resolve10(input logic taken);
    res_valid      = 1'b1;
    res_pc         = 32'h8000_0010;
    res_is_branch  = 1'b1;
    res_taken      = taken;
    res_target     = 32'h8000_0100;
    res_mispredict = 1'b0;
    tick();
    clr_res();
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    fetch_ready  = 1'b0;
    stall        = 1'b0;
    csr_redirect = 1'b0;
    csr_pc       = 32'h0;
    clr_res();

    // ---------------- reset ----------------
    repeat (3) tick();
    chk("rst_pc",    fetch_pc,    32'h8000_0000);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_perf",  perf_pred,   32'd0);
    reset_n     = 1'b1;
    fetch_ready = 1'b1;
    #1;
    chk("rel_valid_low", {31'd0, fetch_valid}, 32'd0);
    tick();
    chk("rel_valid_high", {31'd0, fetch_valid}, 32'd1);
    chk("rel_pc_hold",    fetch_pc,    32'h8000_0000);
    chk("seq_pt0",        {31'd0, pred_taken}, 32'd0);
    chk("seq_tgt0",       pred_target, 32'h8000_0004);

    // ---------------- sequential flow ----------------
    tick();
    chk("seq_pc1", fetch_pc, 32'h8000_0004);
    tick();
    chk("seq_pc2", fetch_pc, 32'h8000_0008);
    stall = 1'b1;
    tick();
    chk("stall_pc1", fetch_pc, 32'h8000_0008);
    tick();
    chk("stall_pc2", fetch_pc, 32'h8000_0008);
    stall = 1'b0;

    // ---------------- allocate on mispredicted taken branch ----------------
    res_valid      = 1'b1;
    res_pc         = 32'h8000_0010;
    res_is_branch  = 1'b1;
    res_taken      = 1'b1;
    res_target     = 32'h8000_0100;
    res_mispredict = 1'b1;
    #1;
    chk("alloc_flush", {31'd0, flush}, 32'd1);
    tick();
    clr_res();
    #1;
    chk("alloc_flush_off", {31'd0, flush}, 32'd0);
    chk("alloc_pc",      fetch_pc,     32'h8000_0100);
    chk("alloc_perf",    perf_pred,    32'd1);
    chk("alloc_mperf",   perf_mispred, 32'd1);

    // Return to 0x80000010 via CSR redirect, then hold it with ready=0.
    csr_redirect = 1'b1;
    csr_pc       = 32'h8000_0010;
    tick();
    csr_redirect = 1'b0;
    fetch_ready  = 1'b0;
    #1;
    chk("hit_pc",  fetch_pc,    32'h8000_0010);
    chk("hit_pt",  {31'd0, pred_taken}, 32'd1);
    chk("hit_tgt", pred_target, 32'h8000_0100);
    tick();
    chk("hold_pc", fetch_pc,    32'h8000_0010);
    chk("hold_tgt", pred_target, 32'h8000_0100);

    // ---------------- counter saturation ----------------
    resolve10(1'b0);  // 10 -> 01
    chk("ctr01_pt",  {31'd0, pred_taken}, 32'd0);
    chk("ctr01_tgt", pred_target, 32'h8000_0014);
    resolve10(1'b0);  // 01 -> 00
    chk("ctr00_pt", {31'd0, pred_taken}, 32'd0);
    resolve10(1'b0);  // 00 stays 00
    chk("ctr00_sat_pt", {31'd0, pred_taken}, 32'd0);
    resolve10(1'b1);  // 00 -> 01
    chk("ctr01b_pt", {31'd0, pred_taken}, 32'd0);
    resolve10(1'b1);  // 01 -> 10
    chk("ctr10_pt", {31'd0, pred_taken}, 32'd1);
    resolve10(1'b1);  // 10 -> 11
    chk("ctr11_pt", {31'd0, pred_taken}, 32'd1);
    resolve10(1'b1);  // 11 stays 11
    chk("ctr11_sat_pt", {31'd0, pred_taken}, 32'd1);
    resolve10(1'b0);  // 11 -> 10, still taken
    chk("ctr10b_pt", {31'd0, pred_taken}, 32'd1);
    chk("ctr_hold_pc", fetch_pc,     32'h8000_0010);
    chk("ctr_perf",    perf_pred,    32'd9);
    chk("ctr_mperf",   perf_mispred, 32'd1);

    // ---------------- PC+4 wrap ----------------
    csr_redirect = 1'b1;
    csr_pc       = 32'hFFFF_FFFC;
    tick();
    csr_redirect = 1'b0;
    fetch_ready  = 1'b1;
    #1;
    chk("wrap_tgt", pred_target, 32'h0000_0000);
    tick();
    chk("wrap_pc", fetch_pc, 32'h0000_0000);

    // ---------------- CSR vs mispredict priority ----------------
    stall          = 1'b1;
    fetch_ready    = 1'b0;
    csr_redirect   = 1'b1;
    csr_pc         = 32'h8000_0200;
    res_valid      = 1'b1;
    res_pc         = 32'h8000_0020;
    res_is_branch  = 1'b1;
    res_taken      = 1'b1;
    res_target     = 32'h8000_0300;
    res_mispredict = 1'b1;
    #1;
    chk("prio_flush", {31'd0, flush}, 32'd1);
    tick();
    csr_redirect = 1'b0;
    clr_res();
    stall        = 1'b0;
    #1;
    chk("prio_pc",    fetch_pc,     32'h8000_0200);
    chk("prio_perf",  perf_pred,    32'd10);
    chk("prio_mperf", perf_mispred, 32'd2);

    // ---------------- mid-run asynchronous reset ----------------
    reset_n = 1'b0;
    #1;
    chk("mrst_pc",    fetch_pc,     32'h8000_0000);
    chk("mrst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("mrst_perf",  perf_mispred, 32'd0);
    tick();
    reset_n      = 1'b1;
    csr_redirect = 1'b1;
    csr_pc       = 32'h8000_0010;
    tick();
    csr_redirect = 1'b0;
    #1;
    chk("mrst_redir_pc", fetch_pc, 32'h8000_0010);
    chk("mrst_no_hit",   {31'd0, pred_taken}, 32'd0);
    chk("mrst_tgt",      pred_target, 32'h8000_0014);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
